// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix serializer: FSM state encoding
// and the index-width rule used for row/column counters.
package matrix_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Counter width for n entries; a single entry still gets a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_serializer.sv
// Captures a parallel R x C matrix and streams it out one element per
// handshake in row-major order, accepting the next matrix on the last beat.
module matrix_serializer
  import matrix_pkg::*;
#(
  parameter int unsigned BITS = 16,
  parameter int unsigned R    = 2,
  parameter int unsigned C    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [R-1:0][C-1:0][BITS-1:0]       a,
  output logic                                in_ready,
  output logic                                drop,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [BITS-1:0]                     out_data,
  output logic [idx_w(R)-1:0]                 out_row,
  output logic [idx_w(C)-1:0]                 out_col,
  output logic                                out_last
);

  localparam int unsigned RW = idx_w(R);
  localparam int unsigned CW = idx_w(C);
  localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(C - 1);

  state_t                        state, state_d;
  logic [RW-1:0]                 row, row_d;
  logic [CW-1:0]                 col, col_d;
  logic [R-1:0][C-1:0][BITS-1:0] held;
  logic                          hs;
  logic                          capture;

  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (row == ROW_LAST) && (col == COL_LAST);
  assign out_data  = held[row][col];
  assign out_row   = row;
  assign out_col   = col;

  // Next state, index advance and capture decision.
  always_comb begin
    state_d  = state;
    row_d    = row;
    col_d    = col;
    hs       = out_valid & out_ready;
    in_ready = (state == IDLE) | (hs & out_last);
    capture  = in_valid & in_ready;

    case (state)
      IDLE: if (capture) state_d = SEND;
      SEND: if (hs && out_last) state_d = capture ? SEND : IDLE;
      default: state_d = IDLE;
    endcase

    if (capture || (hs && out_last)) begin
      row_d = '0;
      col_d = '0;
    end else if (hs) begin
      if (col == COL_LAST) begin
        col_d = '0;
        row_d = row + RW'(1);
      end else begin
        col_d = col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_d;
      row   <= row_d;
      col   <= col_d;
      drop  <= in_valid & ~in_ready;
    end
  end

  // Holding register carries no reset; its content only matters in SEND.
  always_ff @(posedge clk) begin
    if (!rst && capture) held <= a;
  end

endmodule

// File: tb/tb_matrix_serializer.sv
// Scoreboard bench for matrix_serializer: a 2x2 and a 3x1 instance, expected
// elements queued at stimulus time and popped by per-instance monitors.
module tb_matrix_serializer;

  typedef struct {
    logic [15:0] d;
    int          r;
    int          c;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic out_ready;

  logic                   iv22, ir22, dr22, ov22, ol22;
  logic [1:0][1:0][15:0]  a22;
  logic [15:0]            od22;
  logic [0:0]             or22, oc22;

  logic                   iv31, ir31, dr31, ov31, ol31;
  logic [2:0][0:0][15:0]  a31;
  logic [15:0]            od31;
  logic [1:0]             or31;
  logic [0:0]             oc31;

  exp_t q22[$];
  exp_t q31[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   drop_cnt = 0;

  always #5 clk = ~clk;

  matrix_serializer #(.BITS(16), .R(2), .C(2)) u22 (
    .clk(clk), .rst(rst), .in_valid(iv22), .a(a22), .in_ready(ir22),
    .drop(dr22), .out_valid(ov22), .out_ready(out_ready), .out_data(od22),
    .out_row(or22), .out_col(oc22), .out_last(ol22));

  matrix_serializer #(.BITS(16), .R(3), .C(1)) u31 (
    .clk(clk), .rst(rst), .in_valid(iv31), .a(a31), .in_ready(ir31),
    .drop(dr31), .out_valid(ov31), .out_ready(out_ready), .out_data(od31),
    .out_row(or31), .out_col(oc31), .out_last(ol31));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0][1:0][15:0] mk(input logic [15:0] w, x, y, z);
    logic [1:0][1:0][15:0] m;
    m[0][0] = w; m[0][1] = x; m[1][0] = y; m[1][1] = z;
    return m;
  endfunction

  task automatic push22(input logic [15:0] w, x, y, z);
    q22.push_back('{w, 0, 0, 1'b0});
    q22.push_back('{x, 0, 1, 1'b0});
    q22.push_back('{y, 1, 0, 1'b0});
    q22.push_back('{z, 1, 1, 1'b1});
  endtask

  task automatic drain(input int sel, output int cycles);
    cycles = 0;
    while (((sel == 0) ? q22.size() : q31.size()) != 0 && cycles < 50) begin
      tick();
      cycles++;
    end
    check("drain_timeout", ((sel == 0) ? q22.size() : q31.size()), 0);
  endtask

  // Monitors: compare every handshake against the head of the queue.
  always @(negedge clk) begin
    if (!rst && ov22 && out_ready) begin
      if (q22.size() == 0) check("u22_unexpected_beat", od22, 32'hdead);
      else begin
        exp_t e;
        e = q22.pop_front();
        check("u22_data", od22, e.d);
        check("u22_row", or22, e.r);
        check("u22_col", oc22, e.c);
        check("u22_last", ol22, e.l);
      end
    end
    if (!rst && ov31 && out_ready) begin
      if (q31.size() == 0) check("u31_unexpected_beat", od31, 32'hdead);
      else begin
        exp_t e;
        e = q31.pop_front();
        check("u31_data", od31, e.d);
        check("u31_row", or31, e.r);
        check("u31_col", oc31, e.c);
        check("u31_last", ol31, e.l);
      end
    end
    if (dr22) drop_cnt++;
  end

  initial begin
    int cyc, d0;
    rst = 1'b1; out_ready = 1'b1;
    iv22 = 1'b0; iv31 = 1'b0; a22 = '0; a31 = '0;
    tick(); tick();
    check("rst_out_valid", ov22, 0);
    check("rst_in_ready", ir22, 1);
    check("rst_drop", dr22, 0);
    check("rst_out_last", ol22, 0);
    rst = 1'b0;
    tick();

    // Single matrix, full throughput.
    push22(1, 2, 3, 4);
    a22 = mk(1, 2, 3, 4); iv22 = 1'b1;
    tick(); iv22 = 1'b0;
    drain(0, cyc);
    check("single_cycles", cyc, 4);
    check("single_idle", ov22, 0);
    tick();

    // Backpressure on element 2.
    push22(1, 2, 3, 4);
    a22 = mk(1, 2, 3, 4); iv22 = 1'b1;
    tick(); iv22 = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_data", od22, 2);
      check("bp_row", or22, 0);
      check("bp_col", oc22, 1);
      check("bp_valid", ov22, 1);
      tick();
    end
    out_ready = 1'b1;
    drain(0, cyc);
    check("bp_idle", ov22, 0);
    tick();

    // Back-to-back matrices with no bubble.
    d0 = drop_cnt;
    push22(1, 2, 3, 4); push22(5, 6, 7, 8);
    a22 = mk(1, 2, 3, 4); iv22 = 1'b1;
    tick(); iv22 = 1'b0;
    tick(); tick(); tick();
    check("b2b_last_ready", ir22, 1);
    a22 = mk(5, 6, 7, 8); iv22 = 1'b1;
    tick(); iv22 = 1'b0;
    drain(0, cyc);
    check("b2b_cycles", cyc + 4, 8);
    check("b2b_no_drop", drop_cnt - d0, 0);
    check("b2b_idle", ov22, 0);
    tick();

    // Offer during element 2 is dropped.
    d0 = drop_cnt;
    push22(1, 2, 3, 4);
    a22 = mk(1, 2, 3, 4); iv22 = 1'b1;
    tick(); iv22 = 1'b0;
    tick();
    a22 = mk(99, 98, 97, 96); iv22 = 1'b1;
    tick(); iv22 = 1'b0;
    check("drop_pulse", dr22, 1);
    tick();
    check("drop_clear", dr22, 0);
    drain(0, cyc);
    check("drop_count", drop_cnt - d0, 1);
    check("drop_idle", ov22, 0);
    tick();

    // Reset mid-matrix, then a fresh matrix starts at index 00.
    d0 = drop_cnt;
    q22.push_back('{16'd1, 0, 0, 1'b0});
    q22.push_back('{16'd2, 0, 1, 1'b0});
    a22 = mk(1, 2, 3, 4); iv22 = 1'b1;
    tick(); iv22 = 1'b0;
    tick(); tick();
    rst = 1'b1; iv22 = 1'b1; a22 = mk(55, 55, 55, 55);
    tick();
    rst = 1'b0; iv22 = 1'b0;
    check("mid_rst_valid", ov22, 0);
    check("mid_rst_ready", ir22, 1);
    check("mid_rst_drop", dr22, 0);
    check("mid_rst_queue", q22.size(), 0);
    push22(9, 10, 11, 12);
    a22 = mk(9, 10, 11, 12); iv22 = 1'b1;
    tick(); iv22 = 1'b0;
    drain(0, cyc);
    check("post_rst_cycles", cyc, 4);
    check("post_rst_no_drop", drop_cnt - d0, 0);

    // 3x1 column vector.
    q31.push_back('{16'd10, 0, 0, 1'b0});
    q31.push_back('{16'd20, 1, 0, 1'b0});
    q31.push_back('{16'd30, 2, 0, 1'b1});
    a31[0][0] = 16'd10; a31[1][0] = 16'd20; a31[2][0] = 16'd30;
    iv31 = 1'b1;
    tick(); iv31 = 1'b0;
    drain(1, cyc);
    check("r3c1_cycles", cyc, 3);
    check("r3c1_idle", ov31, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
